// File: rtl/mem_bus_pkg.sv
// Shared types for the word-handshake memory bus arbiter.
// State encoding, master indices and the bus-request bundle.
package mem_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_PARK = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] data;
  } bus_req_t;

  function automatic logic [1:0] idx2oh(
    input logic idx
  );
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: on a tie the master that
// did not own the bus last wins. Purely combinational.
module mem_arb_rr2
  import mem_bus_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req0 & req1):  gnt = idx2oh(~last_owner);
      (req0 & ~req1): gnt = idx2oh(M0);
      (~req0 & req1): gnt = idx2oh(M1);
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master burst arbiter in front of one memory slave.
// Optional per-tenure ack limit: MEM_ARB_BURST_LIMIT_EN.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH      = BUS_AW,
  parameter int DATA_WIDTH      = BUS_DW,
  parameter int MAX_BURST_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cs_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  input  logic                  m1_cs_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  s_cs_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  arb_state_t state, state_n;
  logic [1:0] grant, grant_n;
  logic       last_owner, last_n;
  logic [1:0] pick;
  logic       owner;
  logic       own_cs;
  logic       owning;
  bus_req_t   r0, r1, sel;

`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_BURST_WORDS);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             oth_cs;
  logic             at_limit;
`endif

  assign r0 = '{cs:   m0_cs_i,
                we:   m0_we_i,
                addr: BUS_AW'(m0_addr_i),
                data: BUS_DW'(m0_data_i)};
  assign r1 = '{cs:   m1_cs_i,
                we:   m1_we_i,
                addr: BUS_AW'(m1_addr_i),
                data: BUS_DW'(m1_data_i)};

  assign owner  = grant[1];
  assign sel    = owner ? r1 : r0;
  assign own_cs = sel.cs;
  assign owning = (state == ST_OWN);

`ifdef MEM_ARB_BURST_LIMIT_EN
  assign oth_cs   = owner ? m0_cs_i : m1_cs_i;
  assign at_limit = (cnt >= CNT_MAX - 1'b1);
`endif

  mem_arb_rr2 u_rr2 (
    .req0       (m0_cs_i),
    .req1       (m1_cs_i),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_owner <= M1;
`ifdef MEM_ARB_BURST_LIMIT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_owner <= last_n;
`ifdef MEM_ARB_BURST_LIMIT_EN
      cnt        <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_owner;
`ifdef MEM_ARB_BURST_LIMIT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          grant_n = pick;
          state_n = ST_OWN;
`ifdef MEM_ARB_BURST_LIMIT_EN
          cnt_n   = '0;
`endif
        end
      end
      ST_OWN: begin
        if (!own_cs) begin
          last_n  = owner;
          grant_n = 2'b00;
          state_n = ST_IDLE;
        end
`ifdef MEM_ARB_BURST_LIMIT_EN
        else if (s_ack_i) begin
          // revoke only on an ack edge so no word is lost
          if (at_limit && oth_cs) begin
            last_n  = owner;
            grant_n = 2'b00;
            state_n = ST_PARK;
          end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + 1'b1;
          end
        end
`endif
      end
`ifdef MEM_ARB_BURST_LIMIT_EN
      ST_PARK: begin
        grant_n = pick;
        cnt_n   = '0;
        state_n = (pick != 2'b00) ? ST_OWN : ST_IDLE;
      end
`endif
      default: begin
        grant_n = 2'b00;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s_cs_o    = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_data_o = '0;
    if (owning) begin
      s_cs_o   = sel.cs;
      s_we_o   = sel.we;
      s_addr_o = ADDR_WIDTH'(sel.addr);
      s_data_o = DATA_WIDTH'(sel.data);
      if (owner == M1) begin
        m1_ack_o  = s_ack_i;
        m1_data_o = s_data_i;
      end else begin
        m0_ack_o  = s_ack_i;
        m0_data_o = s_data_i;
      end
    end
  end

  assign grant_o = grant;

endmodule
